// File: rtl/residual_add_stream.sv
// rtl/residual_add_stream.sv - element-wise residual adder for two D x D feature-map streams
//
// Purpose: merges two independent pixel streams.
//    - Each stream goes through its own skid FIFO.
//    - Heads are added pairwise as signed fixed point, with optional saturation and ReLU.
//    - The sum is presented on a registered valid/ready output.
//
// Ports:
//    clk, reset               clock, asynchronous active-high reset
//    valid_in_k/pxl_in_k      stream k pixel and valid (k = 1, 2)
//    ready_in_k               stream k FIFO not full
//    pxl_out/valid_out        registered sum pixel and valid
//    ready_out                downstream accepts pxl_out
//    frame_done               one-cycle pulse after the D*D-th output transfer
//    ovf_flag                 sticky: an add overflowed since reset
`timescale 1ns/1ps

// Single-clock FIFO with registered occupancy.
// A word written in one cycle is not visible as non-empty until the next cycle.
// There is no read-through path.
// The storage array is deliberately left out of the reset domain.
module residual_add_stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign wr_ready = !full;
   // Full blocks the write even when a pop frees a slot this same cycle.
   assign do_wr    = wr_valid && !full;
   assign do_rd    = rd_en && !empty;
   assign rd_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module residual_add_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int D          = 220,
   parameter int FIFO_DEPTH = 16,
   parameter int SATURATE   = 1,
   parameter int RELU       = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in_1,
   input  logic [DATA_WIDTH-1:0] pxl_in_1,
   output logic                  ready_in_1,
   input  logic                  valid_in_2,
   input  logic [DATA_WIDTH-1:0] pxl_in_2,
   output logic                  ready_in_2,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic                  frame_done,
   output logic                  ovf_flag
);
   localparam int FRAME = D * D;
   localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [CW-1:0]         LAST_PIXEL = CW'(FRAME - 1);
   localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0] head_1;
   logic [DATA_WIDTH-1:0] head_2;
   logic                  empty_1;
   logic                  empty_2;
   logic                  pop;
   logic                  xfer;
   logic [DATA_WIDTH:0]   sum_ext;
   logic                  ovf;
   logic [DATA_WIDTH-1:0] clamped;
   logic [DATA_WIDTH-1:0] result;
   logic [CW-1:0]         frame_cnt;

   residual_add_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (valid_in_1),
      .wr_data  (pxl_in_1),
      .wr_ready (ready_in_1),
      .rd_en    (pop),
      .rd_data  (head_1),
      .empty    (empty_1)
   );

   residual_add_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_2 (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (valid_in_2),
      .wr_data  (pxl_in_2),
      .wr_ready (ready_in_2),
      .rd_en    (pop),
      .rd_data  (head_2),
      .empty    (empty_2)
   );

   // Both heads leave together, and only when the output register is free or draining.
   assign pop  = !empty_1 && !empty_2 && (!valid_out || ready_out);
   assign xfer = valid_out && ready_out;

   // One guard bit is enough for a two-operand signed add.
   // Overflow shows up as a mismatch between the top two bits.
   assign sum_ext = {head_1[DATA_WIDTH-1], head_1} + {head_2[DATA_WIDTH-1], head_2};
   assign ovf     = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];

   always_comb begin
      clamped = sum_ext[DATA_WIDTH-1:0];
      if ((SATURATE != 0) && ovf) begin
         // The guard bit carries the true sign of the sum.
         clamped = sum_ext[DATA_WIDTH] ? MIN_NEG : MAX_POS;
      end
      result = clamped;
      if ((RELU != 0) && clamped[DATA_WIDTH-1]) begin
         result = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pxl_out   <= '0;
         valid_out <= 1'b0;
         ovf_flag  <= 1'b0;
      end else begin
         if (pop) begin
            pxl_out   <= result;
            valid_out <= 1'b1;
            if (ovf) begin
               ovf_flag <= 1'b1;
            end
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
      end
   end

   // Frame position tracks accepted outputs.
   // Frames run back to back, and the counter wraps on the last pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= xfer && (frame_cnt == LAST_PIXEL);
         if (xfer) begin
            if (frame_cnt == LAST_PIXEL) begin
               frame_cnt <= '0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end
endmodule
